// File: rtl/param_ram_if.sv
// param_ram bus: write port (we/wbe/waddr/wdata), read port (re/raddr),
// clear request (clr) and results (rdata/rvalid/busy).
interface param_ram_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic                  we;
  logic [DATA_W/8-1:0]   wbe;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic                  re;
  logic [ADDR_W-1:0]     raddr;
  logic                  clr;
  logic [DATA_W-1:0]     rdata;
  logic                  rvalid;
  logic                  busy;

  modport master (
    output we, wbe, waddr, wdata,
    output re, raddr, clr,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  we, wbe, waddr, wdata,
    input  re, raddr, clr,
    output rdata, rvalid, busy
  );
endinterface

// File: rtl/param_ram.sv
// param_ram: byte-masked simple dual-port RAM with a self-clearing FSM.
// Ports: clk, rst_n (async low), bus (param_ram_if.slave): we/wbe/waddr/
// wdata write, re/raddr read, clr zeroes the array, rdata/rvalid/busy out.
// Option: PARAM_RAM_OUTREG_EN adds an output stage (read latency 2).
module param_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  param_ram_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                rvalid_q;
  logic                busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.re) begin
            rdata_q  <= mem_q[bus.raddr];
            rvalid_q <= 1'b1;
          end
          if (bus.clr) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Array has no reset; it is zeroed by the CLEAR walk once rst_n rises.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == CLEAR) begin
        mem_q[cnt_q] <= '0;
      end else if (bus.we) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.wbe[i]) begin
            mem_q[bus.waddr][8*i +: 8] <= bus.wdata[8*i +: 8];
          end
        end
      end
    end
  end

`ifdef PARAM_RAM_OUTREG_EN
  logic [DATA_W-1:0]   rdata2_q;
  logic                rvalid2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata2_q  <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      rdata2_q  <= rdata_q;
      rvalid2_q <= rvalid_q;
    end
  end

  assign bus.rdata  = rdata2_q;
  assign bus.rvalid = rvalid2_q;
`else
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
`endif

  assign bus.busy = busy_q;
endmodule

// File: tb/tb_param_ram.sv
// tb_param_ram: random and directed stimulus for param_ram, checked
// against an array model with a clear countdown and read delay line.
module tb_param_ram;
`ifdef PARAM_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errs = 0;
  int checks = 0;

  param_ram_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  param_ram #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [15:0] m_mem [16];
  int          m_left;
  logic        s1_v, s2_v;
  logic [15:0] s1_d, s2_d;
  logic        exp_rv;
  logic [15:0] exp_rd;
  logic        exp_busy;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.we = 0; bus.wbe = 0; bus.waddr = 0; bus.wdata = 0;
    bus.re = 0; bus.raddr = 0; bus.clr = 0;
  endtask

  task automatic model_reset();
    m_left = 16;
    s1_v = 0; s2_v = 0; s1_d = 0; s2_d = 0;
    exp_rv = 0; exp_rd = 0; exp_busy = 1;
  endtask

  task automatic cycle(input logic we, input logic [1:0] wbe,
                       input logic [3:0] wa, input logic [15:0] wd,
                       input logic re, input logic [3:0] ra,
                       input logic clr);
    logic v;
    logic [15:0] d;
    bus.we = we; bus.wbe = wbe; bus.waddr = wa; bus.wdata = wd;
    bus.re = re; bus.raddr = ra; bus.clr = clr;
    v = 0;
    d = s1_d;
    if (m_left > 0) begin
      m_mem[16 - m_left] = 16'h0000;
      m_left--;
    end else begin
      if (re) begin
        v = 1;
        d = m_mem[ra];
      end
      if (we && wbe[0]) m_mem[wa][7:0] = wd[7:0];
      if (we && wbe[1]) m_mem[wa][15:8] = wd[15:8];
      if (clr) m_left = 16;
    end
    s2_v = s1_v; s2_d = s1_d;
    s1_v = v; s1_d = d;
    exp_rv = (LAT == 2) ? s2_v : s1_v;
    exp_rd = (LAT == 2) ? s2_d : s1_d;
    exp_busy = (m_left > 0);
    tick();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++;
    if (bus.rdata !== 16'h0 || bus.rvalid !== 1'b0 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL reset_vals: rdata=%h rvalid=%b busy=%b want 0000 0 1",
               bus.rdata, bus.rvalid, bus.busy);
    end
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n != 16) begin
      errs++;
      $display("FAIL reset_clear_len: busy cycles=%0d want 16", n);
    end
    for (int a = 0; a < 16 + LAT; a++) begin
      cycle(0, 0, 0, 0, a < 16, 4'(a), 0);
      checks++;
      if (bus.rvalid !== exp_rv || bus.rdata !== exp_rd || bus.busy !== exp_busy) begin
        errs++;
        $display("FAIL reset_read a=%0d: got %b/%h/%b want %b/%h/%b", a,
                 bus.rvalid, bus.rdata, bus.busy, exp_rv, exp_rd, exp_busy);
      end
    end
  endtask

  task automatic test_bytemask();
    cycle(1, 2'b11, 3, 16'hA5A5, 0, 0, 0);
    cycle(1, 2'b10, 3, 16'h1200, 0, 0, 0);
    cycle(1, 2'b00, 3, 16'hFFFF, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 3, 0);
    for (int i = 1; i < LAT; i++) begin
      checks++;
      if (bus.rvalid !== 1'b0) begin
        errs++;
        $display("FAIL bytemask_early: rvalid=%b want 0", bus.rvalid);
      end
      cycle(0, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h12A5) begin
      errs++;
      $display("FAIL bytemask_read: rvalid=%b rdata=%h want 1 12a5",
               bus.rvalid, bus.rdata);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== 16'h12A5) begin
      errs++;
      $display("FAIL bytemask_pulse: rvalid=%b rdata=%h want 0 12a5",
               bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_read_first();
    cycle(1, 2'b11, 5, 16'hBEEF, 1, 5, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    if (LAT == 1) begin
      cycle(0, 0, 0, 0, 1, 5, 0);
    end else begin
      cycle(0, 0, 0, 0, 1, 5, 0);
    end
    // LAT=1: old read already shown before; re-issue a check via model
    for (int i = 0; i < LAT; i++) begin
      checks++;
      if (bus.rvalid !== exp_rv || bus.rdata !== exp_rd) begin
        errs++;
        $display("FAIL read_first i=%0d: got %b/%h want %b/%h", i,
                 bus.rvalid, bus.rdata, exp_rv, exp_rd);
      end
      cycle(0, 0, 0, 0, 0, 0, 0);
    end
    checks++;
    if (m_mem[5] !== 16'hBEEF) begin
      errs++;
      $display("FAIL read_first_model: model=%h want beef", m_mem[5]);
    end
    // Direct sequence: same-cycle we/re returns old value literally.
    cycle(1, 2'b11, 6, 16'hCAFE, 1, 6, 0);
    for (int i = 1; i < LAT; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h0000) begin
      errs++;
      $display("FAIL read_first_old: rvalid=%b rdata=%h want 1 0000",
               bus.rvalid, bus.rdata);
    end
    cycle(0, 0, 0, 0, 1, 6, 0);
    for (int i = 1; i < LAT; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 16'hCAFE) begin
      errs++;
      $display("FAIL read_first_new: rvalid=%b rdata=%h want 1 cafe",
               bus.rvalid, bus.rdata);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_clear_collision();
    for (int a = 0; a < 16; a++) cycle(1, 2'b11, 4'(a), 16'hFFFF, 0, 0, 0);
    for (int i = 0; i < LAT; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      if (i == 7) cycle(1, 2'b11, 2, 16'h5555, 1, 2, 1);
      else cycle(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (bus.rvalid !== 1'b0 || bus.busy !== (i < 15)) begin
        errs++;
        $display("FAIL clear_seq i=%0d: rvalid=%b busy=%b want 0 %b", i,
                 bus.rvalid, bus.busy, i < 15);
      end
    end
    for (int a = 0; a < 16 + LAT; a++) begin
      cycle(0, 0, 0, 0, a < 16, 4'(a), 0);
      checks++;
      if (bus.rvalid !== exp_rv || bus.rdata !== exp_rd || bus.busy !== 1'b0) begin
        errs++;
        $display("FAIL clear_read a=%0d: got %b/%h/%b want %b/%h/0", a,
                 bus.rvalid, bus.rdata, bus.busy, exp_rv, exp_rd);
      end
    end
  endtask

  task automatic test_reset_midclear();
    int n;
    cycle(1, 2'b11, 2, 16'h1234, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 2, 0);
    for (int i = 0; i < LAT; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rdata !== 16'h1234) begin
      errs++;
      $display("FAIL midclr_pre: rdata=%h want 1234", bus.rdata);
    end
    cycle(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (bus.rdata !== 16'h0 || bus.rvalid !== 1'b0 || bus.busy !== 1'b1) begin
      errs++;
      $display("FAIL midclr_async: rdata=%h rvalid=%b busy=%b want 0000 0 1",
               bus.rdata, bus.rvalid, bus.busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      cycle(0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (n != 16) begin
      errs++;
      $display("FAIL midclr_len: busy cycles=%0d want 16", n);
    end
    cycle(0, 0, 0, 0, 1, 2, 0);
    for (int i = 1; i < LAT; i++) cycle(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 16'h0000) begin
      errs++;
      $display("FAIL midclr_read: rvalid=%b rdata=%h want 1 0000",
               bus.rvalid, bus.rdata);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 39) == 0);
      checks++;
      if (bus.rvalid !== exp_rv || bus.rdata !== exp_rd || bus.busy !== exp_busy) begin
        errs++;
        $display("FAIL random i=%0d: got %b/%h/%b want %b/%h/%b", i,
                 bus.rvalid, bus.rdata, bus.busy, exp_rv, exp_rd, exp_busy);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++) m_mem[a] = 16'h0;
    idle_inputs();
    test_reset();
    test_bytemask();
    test_read_first();
    test_clear_collision();
    test_reset_midclear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
